// File: rtl/conv3x3_kernel_scheduler.sv
// Kernel-buffer select sequencer: waits for the kernel load, then sweeps every
// (filter, transfer) entry once per accepted window and tags the MAC stream.
module conv3x3_kernel_scheduler #(
    parameter  int MAX_DEPTH = 512,
    localparam int AW        = $clog2(MAX_DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_load_param,
    input  logic [AW:0]   i_filters,
    input  logic [AW:0]   i_transfers,
    input  logic          i_kernel_last,
    input  logic          i_win_valid,
    output logic          o_win_ready,
    input  logic          i_ready,
    output logic          o_sel_valid,
    output logic [AW-1:0] o_sel,
    output logic          o_tag_valid,
    output logic          o_acc_first,
    output logic          o_acc_last,
    output logic [AW:0]   o_filter_idx,
    output logic          o_win_done,
    output logic          o_loaded
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_READY = 2'd1,
        S_SWEEP = 2'd2
    } state_t;

    localparam logic [AW:0] ONE = (AW+1)'(1);

    state_t        r_state;
    state_t        w_state_next;
    logic          w_accept;
    logic          w_issue;

    logic [AW:0]   r_filters;
    logic [AW:0]   r_transfers;
    logic [AW:0]   r_f;
    logic [AW:0]   r_t;
    logic [AW:0]   r_base;

    logic          r_sel_valid;
    logic [AW-1:0] r_sel;
    logic          r_sel_first;
    logic          r_sel_last;
    logic [AW:0]   r_sel_idx;
    logic          r_sel_done;

    logic          r_tag_valid;
    logic          r_tag_first;
    logic          r_tag_last;
    logic [AW:0]   r_tag_idx;
    logic          r_tag_done;

    logic          w_last_t;
    logic          w_last_f;
    logic          w_final;

    assign w_last_t = (r_t == r_transfers - ONE);
    assign w_last_f = (r_f == r_filters - ONE);
    assign w_final  = w_last_t && w_last_f;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_issue      = 1'b0;
        if (i_load_param) begin
            w_state_next = S_LOAD;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (i_kernel_last) begin
                        w_state_next = S_READY;
                    end
                end
                S_READY: begin
                    if (i_win_valid) begin
                        w_accept     = 1'b1;
                        w_state_next = S_SWEEP;
                    end
                end
                S_SWEEP: begin
                    if (i_ready) begin
                        w_issue = 1'b1;
                        if (w_final) begin
                            w_state_next = S_READY;
                        end
                    end
                end
                default: w_state_next = S_LOAD;
            endcase
        end
    end

    // r_base tracks t*r_filters+f without a multiplier.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_filters   <= (AW+1)'(MAX_DEPTH);
            r_transfers <= ONE;
            r_f         <= '0;
            r_t         <= '0;
            r_base      <= '0;
            r_sel_valid <= 1'b0;
            r_sel       <= '0;
            r_sel_first <= 1'b0;
            r_sel_last  <= 1'b0;
            r_sel_idx   <= '0;
            r_sel_done  <= 1'b0;
        end else if (i_load_param) begin
            r_filters   <= (i_filters == '0) ? ONE : i_filters;
            r_transfers <= (i_transfers == '0) ? ONE : i_transfers;
            r_f         <= '0;
            r_t         <= '0;
            r_base      <= '0;
            r_sel_valid <= 1'b0;
            r_sel       <= '0;
            r_sel_first <= 1'b0;
            r_sel_last  <= 1'b0;
            r_sel_idx   <= '0;
            r_sel_done  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_f    <= '0;
                r_t    <= '0;
                r_base <= '0;
            end else if (w_issue) begin
                if (w_last_t) begin
                    r_t    <= '0;
                    r_f    <= r_f + ONE;
                    r_base <= r_f + ONE;
                end else begin
                    r_t    <= r_t + ONE;
                    r_base <= r_base + r_filters;
                end
            end
            r_sel_valid <= w_issue;
            r_sel       <= w_issue ? r_base[AW-1:0] : '0;
            r_sel_first <= w_issue && (r_t == '0);
            r_sel_last  <= w_issue && w_last_t;
            r_sel_idx   <= w_issue ? r_f : '0;
            r_sel_done  <= w_issue && w_final;
        end
    end

    // Tag stage matches the kernel buffer's registered read latency.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tag_valid <= 1'b0;
            r_tag_first <= 1'b0;
            r_tag_last  <= 1'b0;
            r_tag_idx   <= '0;
            r_tag_done  <= 1'b0;
        end else begin
            r_tag_valid <= r_sel_valid;
            r_tag_first <= r_sel_first;
            r_tag_last  <= r_sel_last;
            r_tag_idx   <= r_sel_idx;
            r_tag_done  <= r_sel_done;
        end
    end

    assign o_win_ready  = (r_state == S_READY);
    assign o_loaded     = (r_state != S_LOAD);
    assign o_sel_valid  = r_sel_valid;
    assign o_sel        = r_sel;
    assign o_tag_valid  = r_tag_valid;
    assign o_acc_first  = r_tag_first;
    assign o_acc_last   = r_tag_last;
    assign o_filter_idx = r_tag_idx;
    assign o_win_done   = r_tag_done;

endmodule

// File: tb/tb_conv3x3_kernel_scheduler.sv
// Bench for conv3x3_kernel_scheduler: queue-based sweep model checked every
// cycle, directed scenarios with literal sequences, then randomized traffic.
module tb_conv3x3_kernel_scheduler;

    localparam int MAX_DEPTH = 512;
    localparam int AW        = $clog2(MAX_DEPTH);

    logic          clk;
    logic          rst_n;
    logic          load_param;
    logic [AW:0]   filters;
    logic [AW:0]   transfers;
    logic          kernel_last;
    logic          win_valid;
    logic          win_ready;
    logic          ready;
    logic          sel_valid;
    logic [AW-1:0] sel;
    logic          tag_valid;
    logic          acc_first;
    logic          acc_last;
    logic [AW:0]   filter_idx;
    logic          win_done;
    logic          loaded;

    conv3x3_kernel_scheduler #(.MAX_DEPTH(MAX_DEPTH)) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_load_param (load_param),
        .i_filters    (filters),
        .i_transfers  (transfers),
        .i_kernel_last(kernel_last),
        .i_win_valid  (win_valid),
        .o_win_ready  (win_ready),
        .i_ready      (ready),
        .o_sel_valid  (sel_valid),
        .o_sel        (sel),
        .o_tag_valid  (tag_valid),
        .o_acc_first  (acc_first),
        .o_acc_last   (acc_last),
        .o_filter_idx (filter_idx),
        .o_win_done   (win_done),
        .o_loaded     (loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit v;
        int sel;
        bit first;
        bit last;
        bit done;
        int idx;
    } ent_t;

    ent_t m_q[$];
    ent_t m_selx;
    ent_t m_tag;
    ent_t z;
    bit   m_loaded;
    int   m_F;
    int   m_T;

    task automatic model_reset();
        m_q.delete();
        m_selx   = z;
        m_tag    = z;
        m_loaded = 1'b0;
        m_F      = MAX_DEPTH;
        m_T      = 1;
    endtask

    task automatic build_sweep();
        ent_t e;
        for (int f = 0; f < m_F; f++) begin
            for (int t = 0; t < m_T; t++) begin
                e.v     = 1'b1;
                e.sel   = t * m_F + f;
                e.first = (t == 0);
                e.last  = (t == m_T - 1);
                e.idx   = f;
                e.done  = (f == m_F - 1) && (t == m_T - 1);
                m_q.push_back(e);
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                m_tag  = m_selx;
                m_selx = z;
                if (load_param) begin
                    m_F      = (filters == 0) ? 1 : int'(filters);
                    m_T      = (transfers == 0) ? 1 : int'(transfers);
                    m_loaded = 1'b0;
                    m_q.delete();
                end else if (!m_loaded) begin
                    if (kernel_last) m_loaded = 1'b1;
                end else if (m_q.size() == 0) begin
                    if (win_valid) build_sweep();
                end else if (ready) begin
                    m_selx = m_q.pop_front();
                end
            end
        end
    end

    // ---------------- observation log + per-cycle compare ----------------
    int obs_sel[$];
    int obs_first[$];
    int obs_last[$];
    int obs_idx[$];
    int obs_done;

    task automatic clear_log();
        obs_sel.delete();
        obs_first.delete();
        obs_last.delete();
        obs_idx.delete();
        obs_done = 0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("sel_valid", int'(sel_valid), int'(m_selx.v));
            if (m_selx.v) chk("sel", int'(sel), m_selx.sel);
            chk("tag_valid", int'(tag_valid), int'(m_tag.v));
            chk("acc_first", int'(acc_first), int'(m_tag.first));
            chk("acc_last", int'(acc_last), int'(m_tag.last));
            chk("filter_idx", int'(filter_idx), m_tag.idx);
            chk("win_done", int'(win_done), int'(m_tag.done));
            chk("win_ready", int'(win_ready), int'(m_loaded && m_q.size() == 0));
            chk("loaded", int'(loaded), int'(m_loaded));
            if (sel_valid) obs_sel.push_back(int'(sel));
            if (tag_valid) begin
                obs_first.push_back(int'(acc_first));
                obs_last.push_back(int'(acc_last));
                obs_idx.push_back(int'(filter_idx));
                if (win_done) begin
                    obs_done++;
                    $display("window done: last filter_idx=%0d at %0t", filter_idx, $time);
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    int e_sel[$];
    int e_first[$];
    int e_last[$];
    int e_idx[$];

    task automatic check_log(input string name, input int exp_done);
        chk({name, "_sel_count"}, obs_sel.size(), e_sel.size());
        chk({name, "_tag_count"}, obs_idx.size(), e_idx.size());
        for (int i = 0; i < e_sel.size() && i < obs_sel.size(); i++)
            chk({name, "_sel_seq"}, obs_sel[i], e_sel[i]);
        for (int i = 0; i < e_idx.size() && i < obs_idx.size(); i++) begin
            chk({name, "_first_seq"}, obs_first[i], e_first[i]);
            chk({name, "_last_seq"}, obs_last[i], e_last[i]);
            chk({name, "_idx_seq"}, obs_idx[i], e_idx[i]);
        end
        chk({name, "_done_count"}, obs_done, exp_done);
    endtask

    task automatic load(input int f, input int t);
        @(negedge clk);
        load_param = 1'b1;
        filters    = (AW+1)'(f);
        transfers  = (AW+1)'(t);
        @(negedge clk);
        load_param  = 1'b0;
        kernel_last = 1'b1;
        @(negedge clk);
        kernel_last = 1'b0;
    endtask

    task automatic window();
        win_valid = 1'b1;
        @(negedge clk);
        win_valid = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        load_param  = 1'b0;
        filters     = '0;
        transfers   = '0;
        kernel_last = 1'b0;
        win_valid   = 1'b0;
        ready       = 1'b1;
        clear_log();
        repeat (3) @(negedge clk);
        chk("reset_loaded", int'(loaded), 0);
        chk("reset_win_ready", int'(win_ready), 0);
        chk("reset_sel_valid", int'(sel_valid), 0);
        rst_n = 1'b1;

        // 4x1 sweep
        load(4, 1);
        clear_log();
        window();
        repeat (8) @(negedge clk);
        e_sel   = '{0, 1, 2, 3};
        e_first = '{1, 1, 1, 1};
        e_last  = '{1, 1, 1, 1};
        e_idx   = '{0, 1, 2, 3};
        check_log("f4t1", 1);

        // 3x2 sweep
        load(3, 2);
        clear_log();
        window();
        repeat (10) @(negedge clk);
        e_sel   = '{0, 3, 1, 4, 2, 5};
        e_first = '{1, 0, 1, 0, 1, 0};
        e_last  = '{0, 1, 0, 1, 0, 1};
        e_idx   = '{0, 0, 1, 1, 2, 2};
        check_log("f3t2", 1);

        // 2x3 sweep with a two-cycle stall after the second issue
        load(2, 3);
        clear_log();
        window();
        @(negedge clk);
        @(negedge clk);
        ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ready = 1'b1;
        repeat (10) @(negedge clk);
        e_sel   = '{0, 2, 4, 1, 3, 5};
        e_first = '{1, 0, 0, 1, 0, 0};
        e_last  = '{0, 0, 1, 0, 0, 1};
        e_idx   = '{0, 0, 0, 1, 1, 1};
        check_log("f2t3_stall", 1);

        // abort after three of eight issues
        load(4, 2);
        clear_log();
        window();
        repeat (3) @(negedge clk);
        load_param = 1'b1;
        @(negedge clk);
        load_param = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_sel_count", obs_sel.size(), 3);
        chk("abort_done_count", obs_done, 0);
        chk("abort_win_ready", int'(win_ready), 0);
        chk("abort_loaded", int'(loaded), 0);
        kernel_last = 1'b1;
        @(negedge clk);
        kernel_last = 1'b0;
        @(negedge clk);
        chk("reload_win_ready", int'(win_ready), 1);

        // zero parameters act as 1x1; kernel_last in READY is ignored
        load(0, 0);
        kernel_last = 1'b1;
        @(negedge clk);
        kernel_last = 1'b0;
        @(negedge clk);
        chk("ready_ignores_klast", int'(win_ready), 1);
        clear_log();
        window();
        repeat (4) @(negedge clk);
        e_sel   = '{0};
        e_first = '{1};
        e_last  = '{1};
        e_idx   = '{0};
        check_log("f0t0", 1);

        // asynchronous reset in the middle of a sweep
        load(8, 1);
        window();
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sel_valid", int'(sel_valid), 0);
        chk("arst_sel", int'(sel), 0);
        chk("arst_tag_valid", int'(tag_valid), 0);
        chk("arst_filter_idx", int'(filter_idx), 0);
        chk("arst_win_ready", int'(win_ready), 0);
        chk("arst_loaded", int'(loaded), 0);
        @(negedge clk);
        rst_n     = 1'b1;
        win_valid = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_refused", int'(win_ready), 0);
        win_valid   = 1'b0;
        kernel_last = 1'b1;
        @(negedge clk);
        kernel_last = 1'b0;
        clear_log();
        window();
        repeat (520) @(negedge clk);
        chk("default_sel_count", obs_sel.size(), MAX_DEPTH);
        if (obs_sel.size() == MAX_DEPTH) chk("default_last_sel", obs_sel[MAX_DEPTH-1], MAX_DEPTH - 1);
        chk("default_done_count", obs_done, 1);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            load_param  = ($urandom_range(0, 99) < 2);
            filters     = (AW+1)'($urandom_range(0, 8));
            transfers   = (AW+1)'($urandom_range(0, 8));
            kernel_last = ($urandom_range(0, 99) < 10);
            win_valid   = ($urandom_range(0, 99) < 50);
            ready       = ($urandom_range(0, 99) < 80);
        end
        @(negedge clk);
        load_param  = 1'b0;
        kernel_last = 1'b0;
        win_valid   = 1'b0;
        ready       = 1'b1;
        repeat (80) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
